// File: rtl/proc_out_capture.sv
// Capture stage for the processor's output bus: records each new nonzero value into a
// small FIFO read over valid/ready, with sticky overflow and no-output watchdog flags.
module proc_out_capture #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] proc_out,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [7:0]       count,
  output logic             overflow,
  output logic             timeout,
  output logic             armed
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [TW-1:0]    timer_inc;
  logic [7:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_req;
  logic push_ok;
  logic pop;
  logic empty;
  logic full;

  assign timer_inc = timer_q + TW'(1);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    push_req  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARMED;
          prev_d  = '0;
          timer_d = '0;
        end
      end

      ST_ARMED: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (proc_out != prev_q && proc_out != '0) begin
          push_req = 1'b1;
          prev_d   = proc_out;
          timer_d  = '0;
        end else begin
          // A drop to zero re-enables capture of a repeated value; it is not activity.
          if (proc_out == '0) prev_d = '0;
          if (TIMEOUT != 0) begin
            timer_d = timer_inc;
            if (timer_inc == TIMER_MAX) begin
              state_d   = ST_TIMEOUT;
              timeout_d = 1'b1;
            end
          end
        end
      end

      ST_TIMEOUT: begin
        state_d = ST_TIMEOUT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && rd_ready;
  // On a full FIFO the slot being popped this edge is the one written, so both may proceed.
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (push_ok && count_q != 8'hFF) count_d = count_q + 8'd1;
    if (push_req && !push_ok) overflow_d = 1'b1;
  end

  // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      timer_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      // NOTE: the storage is reset too, because rd_data reads it directly and must be 0 in reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= proc_out;
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;
  assign armed    = (state_q == ST_ARMED);

endmodule

// File: tb/tb_proc_out_capture.sv
// Self-checking bench for proc_out_capture: vector tables plus a read scoreboard.
module tb_proc_out_capture;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic             start    = 1'b0;
  logic [WIDTH-1:0] proc_out = '0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [7:0]       count;
  logic             overflow;
  logic             timeout;
  logic             armed;

  proc_out_capture #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .proc_out(proc_out),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .count   (count),
    .overflow(overflow),
    .timeout (timeout),
    .armed   (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pout;
    logic             rdy;
    logic             push;
    logic             exp_valid;
    logic [7:0]       exp_count;
    logic             exp_ovf;
  } vec_t;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] sb [$];
  vec_t             vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    start    = 1'b0;
    proc_out = '0;
    rd_ready = 1'b0;
    sb.delete();
    #12;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    check("arm_armed", 32'(armed), 32'd1);
  endtask

  // Compares the head against the scoreboard whenever a pop is about to happen.
  task automatic check_pop(input string name);
    logic [WIDTH-1:0] exp;
    if (rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        check({name, "_unexpected_pop"}, 32'(rd_valid), 32'd0);
      end else begin
        exp = sb.pop_front();
        check({name, "_rd_data"}, 32'(rd_data), 32'(exp));
      end
    end
  endtask

  task automatic run_vectors(input string name);
    foreach (vecs[i]) begin
      proc_out = vecs[i].pout;
      rd_ready = vecs[i].rdy;
      check_pop(name);
      if (vecs[i].push) sb.push_back(vecs[i].pout);
      tick();
      check({name, "_valid"}, 32'(rd_valid), 32'(vecs[i].exp_valid));
      check({name, "_count"}, 32'(count), 32'(vecs[i].exp_count));
      check({name, "_ovf"}, 32'(overflow), 32'(vecs[i].exp_ovf));
    end
    rd_ready = 1'b0;
    vecs.delete();
  endtask

  task automatic drain(input string name, input int max_cycles);
    rd_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (!rd_valid) break;
      check_pop(name);
      tick();
    end
    rd_ready = 1'b0;
    check({name, "_empty_after_drain"}, 32'(rd_valid), 32'd0);
    check({name, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  function automatic vec_t mk(input logic [WIDTH-1:0] p, input logic push,
                              input logic v, input logic [7:0] c, input logic o);
    vec_t r;
    r.pout = p; r.rdy = 1'b0; r.push = push;
    r.exp_valid = v; r.exp_count = c; r.exp_ovf = o;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset held with activity on the inputs: nothing captured.
    reset    = 1'b1;
    start    = 1'b0;
    proc_out = 8'd5;
    repeat (10) tick();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_no_capture_valid", 32'(rd_valid), 32'd0);
    check("idle_no_capture_count", 32'(count), 32'd0);
    check("idle_armed", 32'(armed), 32'd0);

    // Single capture, held value not re-pushed, pop empties.
    do_reset();
    arm();
    repeat (2) tick();
    proc_out = 8'd7;
    sb.push_back(8'd7);
    tick();
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_data", 32'(rd_data), 32'd7);
    check("single_count", 32'(count), 32'd1);
    repeat (9) tick();
    check("single_hold_count", 32'(count), 32'd1);
    check("single_hold_valid", 32'(rd_valid), 32'd1);
    drain("single", 4);

    // Overflow and ordering.
    do_reset();
    arm();
    vecs.push_back(mk(8'd1, 1'b1, 1'b1, 8'd1, 1'b0));
    vecs.push_back(mk(8'd2, 1'b1, 1'b1, 8'd2, 1'b0));
    vecs.push_back(mk(8'd3, 1'b1, 1'b1, 8'd3, 1'b0));
    vecs.push_back(mk(8'd4, 1'b1, 1'b1, 8'd4, 1'b0));
    vecs.push_back(mk(8'd5, 1'b0, 1'b1, 8'd4, 1'b1));
    run_vectors("ovf");
    check("ovf_head", 32'(rd_data), 32'd1);
    drain("ovf", 8);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    arm();
    vecs.push_back(mk(8'd1, 1'b1, 1'b1, 8'd1, 1'b0));
    vecs.push_back(mk(8'd2, 1'b1, 1'b1, 8'd2, 1'b0));
    vecs.push_back(mk(8'd3, 1'b1, 1'b1, 8'd3, 1'b0));
    vecs.push_back(mk(8'd4, 1'b1, 1'b1, 8'd4, 1'b0));
    run_vectors("full");
    proc_out = 8'd9;
    rd_ready = 1'b1;
    check_pop("full_pp");
    sb.push_back(8'd9);
    tick();
    rd_ready = 1'b0;
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_count", 32'(count), 32'd5);
    check("full_pp_head", 32'(rd_data), 32'd2);
    drain("full_pp", 8);

    // Zero and repeat filter: 3,3,0,3,0,0,6 pushes 3,3,6.
    do_reset();
    arm();
    vecs.push_back(mk(8'd3, 1'b1, 1'b1, 8'd1, 1'b0));
    vecs.push_back(mk(8'd3, 1'b0, 1'b1, 8'd1, 1'b0));
    vecs.push_back(mk(8'd0, 1'b0, 1'b1, 8'd1, 1'b0));
    vecs.push_back(mk(8'd3, 1'b1, 1'b1, 8'd2, 1'b0));
    vecs.push_back(mk(8'd0, 1'b0, 1'b1, 8'd2, 1'b0));
    vecs.push_back(mk(8'd0, 1'b0, 1'b1, 8'd2, 1'b0));
    vecs.push_back(mk(8'd6, 1'b1, 1'b1, 8'd3, 1'b0));
    run_vectors("filt");
    drain("filt", 8);

    // Watchdog: armed at edge N, timeout after edge N+TIMEOUT.
    do_reset();
    arm();
    repeat (TIMEOUT - 1) tick();
    check("wd_before_timeout", 32'(timeout), 32'd0);
    check("wd_before_armed", 32'(armed), 32'd1);
    tick();
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_left_armed", 32'(armed), 32'd0);
    proc_out = 8'd8;
    repeat (3) tick();
    check("wd_no_capture_count", 32'(count), 32'd0);
    check("wd_no_capture_valid", 32'(rd_valid), 32'd0);
    check("wd_timeout_sticky", 32'(timeout), 32'd1);

    // Asynchronous reset between edges with two entries queued.
    do_reset();
    arm();
    vecs.push_back(mk(8'd4, 1'b1, 1'b1, 8'd1, 1'b0));
    vecs.push_back(mk(8'd5, 1'b1, 1'b1, 8'd2, 1'b0));
    run_vectors("areset_fill");
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("areset_valid", 32'(rd_valid), 32'd0);
    check("areset_data", 32'(rd_data), 32'd0);
    check("areset_count", 32'(count), 32'd0);
    check("areset_armed", 32'(armed), 32'd0);
    check("areset_ovf", 32'(overflow), 32'd0);
    check("areset_timeout", 32'(timeout), 32'd0);
    sb.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
